// File: rtl/fib_mem_reader.sv
// fib_mem_reader: reads F(0)..F(n-1) back from the Fibonacci result memory,
// streams each word over valid/ready and checks it against an internally
// generated reference sequence, flagging the first mismatching index.
`timescale 1ns/1ps

module fib_mem_reader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,        // asynchronous, active-low
    input  logic              start,
    input  logic [ADDR_W-1:0] n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] err_index
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WT,
        OUT,
        DONE
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [ADDR_W-1:0]   idx;
    logic [ADDR_W-1:0]   n_lat;
    logic [DATA_W-1:0]   ref_a;
    logic [DATA_W-1:0]   ref_b;
    logic [ADDR_W:0]     idx_inc;
    logic                last_term;
    logic                handshake;

    // One extra bit so idx+1 can reach n_lat even when n_lat is the maximum count.
    assign idx_inc   = {1'b0, idx} + (ADDR_W + 1)'(1);
    assign last_term = (idx_inc == {1'b0, n_lat});
    assign handshake = (state == OUT) && out_ready;

    // Outputs are pure decodes of the registered state.
    assign mem_rd    = (state == RD);
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    // NOTE: the default assignment before the case keeps this purely
    // combinational; a path that forgets state_nx would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (n == '0) ? DONE : RD;
                end
            end
            RD:   state_nx = WT;
            WT:   state_nx = OUT;
            OUT: begin
                if (out_ready) begin
                    state_nx = last_term ? DONE : RD;
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: run setup, read addressing, capture/compare and reference stepping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_lat     <= '0;
            idx       <= '0;
            mem_addr  <= '0;
            out_data  <= '0;
            out_index <= '0;
            error     <= 1'b0;
            err_index <= '0;
            ref_a     <= '0;
            ref_b     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        n_lat     <= n;
                        idx       <= '0;
                        error     <= 1'b0;
                        err_index <= '0;
                        ref_a     <= '0;
                        ref_b     <= DATA_W'(1);
                        // mem_addr only moves when a read is about to be issued.
                        if (n != '0) begin
                            mem_addr <= '0;
                        end
                    end
                end
                WT: begin
                    out_data  <= mem_rdata;
                    out_index <= idx;
                    // Only the first mismatch is recorded; error is sticky for the run.
                    if ((mem_rdata != ref_a) && !error) begin
                        error     <= 1'b1;
                        err_index <= idx;
                    end
                end
                OUT: begin
                    if (handshake) begin
                        // Reference advances on its own, independent of memory data.
                        ref_a <= ref_b;
                        ref_b <= ref_a + ref_b;
                        if (!last_term) begin
                            idx      <= idx_inc[ADDR_W-1:0];
                            mem_addr <= idx_inc[ADDR_W-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fib_mem_reader.sv
// Testbench for fib_mem_reader: table of read-back runs against a behavioural
// memory, plus a hand-written mid-run reset sequence.
`timescale 1ns/1ps

module tb_fib_mem_reader;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] n = '0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_index;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W-1:0] err_index;

    fib_mem_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .n         (n),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_index (err_index)
    );

    always #5 clk = ~clk;

    // Behavioural memory: read data registered on the mem_rd edge.
    logic [DATA_W-1:0] mem     [64];
    logic [DATA_W-1:0] exp_mem [64];

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int          n;
        int          bad_addr;   // -1: memory holds the true sequence
        logic [31:0] bad_val;
        bit          toggle;     // out_ready backpressure pattern
        bit          exp_err;
        int          exp_err_idx;
    } vec_t;

    task automatic preload(input int bad_addr, input logic [31:0] bad_val);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] t;
        a = 32'd0;
        b = 32'd1;
        for (int i = 0; i < 64; i++) begin
            exp_mem[i] = a;
            t = a + b;
            a = b;
            b = t;
        end
        if (bad_addr >= 0) exp_mem[bad_addr] = bad_val;
        for (int i = 0; i < 64; i++) mem[i] = exp_mem[i];
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_rd"},    64'(mem_rd),    0);
        check({tag, "_out_valid"}, 64'(out_valid), 0);
        check({tag, "_busy"},      64'(busy),      0);
        check({tag, "_done"},      64'(done),      0);
        check({tag, "_error"},     64'(error),     0);
        check({tag, "_mem_addr"},  64'(mem_addr),  0);
        check({tag, "_out_data"},  64'(out_data),  0);
        check({tag, "_out_index"}, 64'(out_index), 0);
        check({tag, "_err_index"}, 64'(err_index), 0);
    endtask

    task automatic run(input vec_t v, input string tag);
        int c, hs, rds, dones, first_v, done_c, busy_cyc;
        bit fin, exp_e;
        preload(v.bad_addr, v.bad_val);
        @(negedge clk);
        start     = 1'b1;
        n         = ADDR_W'(v.n);
        out_ready = 1'b1;
        @(posedge clk);             // start accepted at this edge
        c = 0; hs = 0; rds = 0; dones = 0; first_v = 0; done_c = 0; busy_cyc = 0;
        fin = 1'b0;
        while (!fin && c < 1000) begin
            @(negedge clk);
            c++;
            // Mid-run n change and a second start must both be ignored.
            n         = ADDR_W'(7);
            start     = (c == 2) && (v.n > 0);
            out_ready = v.toggle ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
            if (busy) busy_cyc++;
            if (mem_rd) rds++;
            if (out_valid) begin
                if (first_v == 0) first_v = c;
                exp_e = v.exp_err && (hs >= v.exp_err_idx);
                check({tag, "_out_data"},  64'(out_data),  64'(exp_mem[hs]));
                check({tag, "_out_index"}, 64'(out_index), 64'(hs));
                check({tag, "_error"},     64'(error),     64'(exp_e));
                if (exp_e) check({tag, "_err_index"}, 64'(err_index), 64'(v.exp_err_idx));
                if (hs == 47) check({tag, "_f47"}, 64'(out_data), 64'd2971215073);
                if (hs == 48) check({tag, "_f48"}, 64'(out_data), 64'd512559680);
                if (out_ready) hs++;
            end
            if (done) begin
                dones++;
                if (done_c == 0) done_c = c;
            end else if (dones > 0) begin
                check({tag, "_busy_after_done"}, 64'(busy), 0);
                fin = 1'b1;
            end
        end
        start = 1'b0;
        if (!fin) check({tag, "_timeout"}, 64'(c), 0);
        check({tag, "_handshakes"}, 64'(hs),    64'(v.n));
        check({tag, "_mem_reads"},  64'(rds),   64'(v.n));
        check({tag, "_done_count"}, 64'(dones), 1);
        check({tag, "_final_err"},  64'(error), 64'(v.exp_err));
        if (v.n > 0) check({tag, "_first_valid"}, 64'(first_v), 3);
        if (!v.toggle) begin
            check({tag, "_done_cycle"}, 64'(done_c),   64'(3 * v.n + 1));
            check({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(3 * v.n + 1));
        end
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{10, -1, 32'd0, 1'b0, 1'b0, 0};   // clean run
        vecs[1] = '{10,  5, 32'd6, 1'b0, 1'b1, 5};   // address 5 corrupted
        vecs[2] = '{48, -1, 32'd0, 1'b0, 1'b0, 0};   // last term F(47)
        vecs[3] = '{49, -1, 32'd0, 1'b0, 1'b0, 0};   // F(48) wraps modulo 2^32
        vecs[4] = '{ 4, -1, 32'd0, 1'b1, 1'b0, 0};   // backpressure
        vecs[5] = '{ 0, -1, 32'd0, 1'b0, 1'b0, 0};   // empty run

        preload(-1, 32'd0);
        #12;
        check_all_zero("por");
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run(vecs[i], $sformatf("v%0d", i));
        end

        // Mid-run reset with a pending error, then a fresh short run.
        begin
            int  k;
            bit  hit;
            vec_t v2;
            preload(1, 32'd99);
            @(negedge clk);
            start = 1'b1;
            n     = ADDR_W'(10);
            out_ready = 1'b1;
            @(negedge clk);
            start = 1'b0;
            hit = 1'b0;
            for (k = 0; k < 100 && !hit; k++) begin
                if (out_valid && out_index == ADDR_W'(3)) hit = 1'b1;
                else @(negedge clk);
            end
            check("rst_reach_idx3", 64'(hit), 1);
            check("rst_error_before", 64'(error), 1);
            rst = 1'b0;
            #1;
            check_all_zero("rst_mid");
            @(negedge clk);
            check("rst_hold_done", 64'(done), 0);
            @(negedge clk);
            check("rst_hold_busy", 64'(busy), 0);
            rst = 1'b1;
            v2 = '{2, -1, 32'd0, 1'b0, 1'b0, 0};
            run(v2, "after_rst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
